// File: rtl/tcam_pkg.sv
// Shared types and default sizing for the TCAM search engine and its banks.
package tcam_pkg;

    localparam int DEF_SUB_W = 7;
    localparam int DEF_N_BLK = 4;
    localparam int DEF_DEPTH = 64;

    typedef enum logic [1:0] {
        OP_SEARCH = 2'd0,
        OP_WRITE  = 2'd1,
        OP_ERASE  = 2'd2
    } op_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SRCH_RD   = 3'd1,
        SRCH_EVAL = 3'd2,
        WR_SWEEP  = 3'd3,
        RESP      = 3'd4
    } state_e;

endpackage

// File: rtl/tcam_vtb_bank.sv
// One transposed TCAM bank: a row per sub-key value, one column bit per entry.
module tcam_vtb_bank #(
    parameter int SUB_W = 7,
    parameter int DEPTH = 64
) (
    input  logic               clk_i,
    input  logic               rd_en_i,
    input  logic [SUB_W-1:0]   rd_addr_i,
    output logic [DEPTH-1:0]   rd_data_o,
    input  logic               wr_en_i,
    input  logic [SUB_W-1:0]   wr_addr_i,
    input  logic [DEPTH-1:0]   wr_be_i,
    input  logic [DEPTH-1:0]   wr_data_i
);

    logic [DEPTH-1:0] mem_q [2**SUB_W];
    logic [DEPTH-1:0] rd_q;

    // Contents are deliberately left unreset; stale columns are hidden by entry_valid.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_be_i[i]) begin
                    mem_q[wr_addr_i][i] <= wr_data_i[i];
                end
            end
        end
        if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/tcam_search_engine.sv
// TCAM search engine: N_BLK transposed banks ANDed per entry, with a row-sweep
// writer that programs one entry column across all banks.
module tcam_search_engine
    import tcam_pkg::*;
#(
    parameter int SUB_W = DEF_SUB_W,
    parameter int N_BLK = DEF_N_BLK,
    parameter int DEPTH = DEF_DEPTH,
    localparam int QUERY_W = SUB_W * N_BLK,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [1:0]         req_op_i,
    input  logic [QUERY_W-1:0] req_key_i,
    input  logic [QUERY_W-1:0] req_mask_i,
    input  logic [IDX_W-1:0]   req_idx_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_hit_o,
    output logic               rsp_multi_o,
    output logic [IDX_W-1:0]   rsp_idx_o,
    output logic [DEPTH-1:0]   rsp_vec_o
);

    state_e             state_q, state_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [SUB_W-1:0]   row_q, row_d;
    logic [QUERY_W-1:0] key_q, key_d;
    logic [QUERY_W-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         op_q, op_d;
    logic [DEPTH-1:0]   match_q, match_d;
    logic               hit_q, hit_d;
    logic               multi_q, multi_d;
    logic [IDX_W-1:0]   ridx_q, ridx_d;
    logic [DEPTH-1:0]   vec_q, vec_d;

    logic [DEPTH-1:0]   bank_rd [N_BLK];
    logic [N_BLK-1:0]   row_hit;
    logic [DEPTH-1:0]   and_all;
    logic [DEPTH-1:0]   wr_be;
    logic [IDX_W-1:0]   lo_idx;
    logic               rd_en;
    logic               wr_en;

    assign wr_be = DEPTH'(1) << idx_q;

    generate
        for (genvar gi = 0; gi < N_BLK; gi++) begin : g_bank
            // A row belongs to the entry when it agrees with the key on every cared-for bit.
            assign row_hit[gi] = ((row_q ^ key_q[gi*SUB_W +: SUB_W])
                                  & ~mask_q[gi*SUB_W +: SUB_W]) == '0;

            tcam_vtb_bank #(
                .SUB_W (SUB_W),
                .DEPTH (DEPTH)
            ) u_bank (
                .clk_i     (clk_i),
                .rd_en_i   (rd_en),
                .rd_addr_i (req_key_i[gi*SUB_W +: SUB_W]),
                .rd_data_o (bank_rd[gi]),
                .wr_en_i   (wr_en),
                .wr_addr_i (row_q),
                .wr_be_i   (wr_be),
                .wr_data_i ({DEPTH{row_hit[gi]}})
            );
        end
    endgenerate

    always_comb begin
        and_all = '1;
        for (int b = 0; b < N_BLK; b++) begin
            and_all = and_all & bank_rd[b];
        end
    end

    // Descending scan leaves the lowest set index as the final winner.
    always_comb begin
        lo_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_q[i]) begin
                lo_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            valid_q <= '0;
            row_q   <= '0;
            key_q   <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            op_q    <= '0;
            match_q <= '0;
            hit_q   <= 1'b0;
            multi_q <= 1'b0;
            ridx_q  <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            row_q   <= row_d;
            key_q   <= key_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            match_q <= match_d;
            hit_q   <= hit_d;
            multi_q <= multi_d;
            ridx_q  <= ridx_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        row_d   = row_q;
        key_d   = key_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        op_d    = op_q;
        match_d = match_q;
        hit_d   = hit_q;
        multi_d = multi_q;
        ridx_d  = ridx_q;
        vec_d   = vec_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d   = req_op_i;
                    key_d  = req_key_i;
                    mask_d = req_mask_i;
                    idx_d  = req_idx_i;
                    case (req_op_i)
                        OP_SEARCH: begin
                            rd_en   = 1'b1;
                            state_d = SRCH_RD;
                        end
                        OP_WRITE: begin
                            valid_d[req_idx_i] = 1'b0;
                            row_d   = '0;
                            state_d = WR_SWEEP;
                        end
                        OP_ERASE: begin
                            valid_d[req_idx_i] = 1'b0;
                            state_d = SRCH_EVAL;
                        end
                        default: state_d = SRCH_EVAL;
                    endcase
                end
            end
            SRCH_RD: begin
                match_d = and_all & valid_q;
                state_d = SRCH_EVAL;
            end
            SRCH_EVAL: begin
                hit_d   = 1'b0;
                multi_d = 1'b0;
                vec_d   = '0;
                ridx_d  = '0;
                if (op_q == OP_SEARCH) begin
                    hit_d   = |match_q;
                    multi_d = |(match_q & (match_q - DEPTH'(1)));
                    ridx_d  = lo_idx;
                    vec_d   = match_q;
                end else if (op_q == OP_ERASE) begin
                    ridx_d  = idx_q;
                end
                state_d = RESP;
            end
            WR_SWEEP: begin
                wr_en = 1'b1;
                row_d = row_q + 1'b1;
                if (row_q == '1) begin
                    valid_d[idx_q] = 1'b1;
                    hit_d   = 1'b0;
                    multi_d = 1'b0;
                    ridx_d  = idx_q;
                    vec_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_hit_o   = hit_q;
    assign rsp_multi_o = multi_q;
    assign rsp_idx_o   = ridx_q;
    assign rsp_vec_o   = vec_q;

endmodule

// File: tb/tb_tcam_search_engine.sv
// Self-checking bench for tcam_search_engine against an entry-list TCAM model.
module tb_tcam_search_engine;

    localparam int SUB_W = 7;
    localparam int N_BLK = 4;
    localparam int DEPTH = 64;
    localparam int QW    = SUB_W * N_BLK;
    localparam int IW    = $clog2(DEPTH);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [1:0]    req_op_i = 2'd0;
    logic [QW-1:0] req_key_i = '0;
    logic [QW-1:0] req_mask_i = '0;
    logic [IW-1:0] req_idx_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic          rsp_hit_o;
    logic          rsp_multi_o;
    logic [IW-1:0] rsp_idx_o;
    logic [DEPTH-1:0] rsp_vec_o;

    int errors = 0;
    int checks = 0;

    logic [QW-1:0] m_key  [DEPTH];
    logic [QW-1:0] m_mask [DEPTH];
    bit            m_valid[DEPTH];

    always #5 clk_i = ~clk_i;

    tcam_search_engine #(.SUB_W(SUB_W), .N_BLK(N_BLK), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_key_i   (req_key_i),
        .req_mask_i  (req_mask_i),
        .req_idx_i   (req_idx_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_hit_o   (rsp_hit_o),
        .rsp_multi_o (rsp_multi_o),
        .rsp_idx_o   (rsp_idx_o),
        .rsp_vec_o   (rsp_vec_o)
    );

    function automatic logic [DEPTH-1:0] model_vec(input logic [QW-1:0] k);
        logic [DEPTH-1:0] v = '0;
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && (((k ^ m_key[i]) & ~m_mask[i]) == '0)) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [IW-1:0] lowest(input logic [DEPTH-1:0] v);
        for (int i = 0; i < DEPTH; i++) if (v[i]) return IW'(i);
        return '0;
    endfunction

    // Performs one complete request/response transaction and updates the model.
    task automatic send(input logic [1:0] op, input logic [QW-1:0] key, input logic [QW-1:0] mask,
                        input logic [IW-1:0] idx, output int lat, output logic hit, output logic multi,
                        output logic [IW-1:0] ridx, output logic [DEPTH-1:0] vec, output bit tout);
        int n = 0;
        while (!req_ready_o && n < 1000) begin @(posedge clk_i); #1; n++; end
        req_valid_i = 1'b1; req_op_i = op; req_key_i = key; req_mask_i = mask; req_idx_i = idx;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        req_key_i = QW'($urandom); req_mask_i = QW'($urandom); req_idx_i = IW'($urandom);
        n = 0;
        while (!rsp_valid_o && n < 500) begin @(posedge clk_i); #1; n++; end
        tout = (n >= 500);
        lat = n; hit = rsp_hit_o; multi = rsp_multi_o; ridx = rsp_idx_o; vec = rsp_vec_o;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        if (op == 2'd1) begin m_key[idx] = key; m_mask[idx] = mask; m_valid[idx] = 1'b1; end
        if (op == 2'd2) m_valid[idx] = 1'b0;
        $display("txn op=%0d key=%h mask=%h idx=%0d lat=%0d hit=%0b multi=%0b ridx=%0d vec=%h",
                 op, key, mask, idx, lat, hit, multi, ridx, vec);
    endtask

    task automatic test_reset();
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid_o); end
        checks++; if ({rsp_hit_o, rsp_multi_o, rsp_idx_o, rsp_vec_o} !== '0)
            begin errors++; $display("FAIL reset_rsp_fields got=%b/%b/%0d/%h exp=0", rsp_hit_o, rsp_multi_o, rsp_idx_o, rsp_vec_o); end
    endtask

    task automatic test_search_empty();
        int lat; logic hit, multi; logic [IW-1:0] ridx; logic [DEPTH-1:0] vec; bit to;
        send(2'd0, '0, '0, '0, lat, hit, multi, ridx, vec, to);
        checks++; if (to || lat != 2) begin errors++; $display("FAIL empty_latency got=%0d exp=2 timeout=%0b", lat, to); end
        checks++; if ({hit, multi, ridx, vec} !== '0) begin errors++; $display("FAIL empty_result got=%b/%b/%0d/%h exp=0", hit, multi, ridx, vec); end
    endtask

    task automatic test_write_basic();
        int lat; logic hit, multi; logic [IW-1:0] ridx; logic [DEPTH-1:0] vec; bit to;
        send(2'd1, 28'h1234567, '0, 6'd5, lat, hit, multi, ridx, vec, to);
        checks++; if (to || lat != (1 << SUB_W)) begin errors++; $display("FAIL write_latency got=%0d exp=%0d", lat, 1 << SUB_W); end
        checks++; if (ridx !== 6'd5 || hit !== 1'b0 || vec !== '0) begin errors++; $display("FAIL write_ack got=%0d/%b/%h exp=5/0/0", ridx, hit, vec); end
        send(2'd0, 28'h1234567, '0, '0, lat, hit, multi, ridx, vec, to);
        checks++; if (hit !== 1'b1 || ridx !== 6'd5 || multi !== 1'b0 || vec !== model_vec(28'h1234567))
            begin errors++; $display("FAIL write_search_hit got=%b/%0d/%b/%h exp=1/5/0/%h", hit, ridx, multi, vec, model_vec(28'h1234567)); end
        send(2'd0, 28'h1234566, '0, '0, lat, hit, multi, ridx, vec, to);
        checks++; if (hit !== 1'b0 || vec !== '0 || ridx !== '0) begin errors++; $display("FAIL write_search_miss got=%b/%0d/%h exp=0/0/0", hit, ridx, vec); end
    endtask

    task automatic test_mask();
        int lat; logic hit, multi; logic [IW-1:0] ridx; logic [DEPTH-1:0] vec; bit to;
        logic [QW-1:0] keys [3] = '{28'h00000A5, 28'h00000B5, 28'h00000AB};
        logic [DEPTH-1:0] ev;
        send(2'd1, 28'h00000AB, 28'h000000F, 6'd9, lat, hit, multi, ridx, vec, to);
        send(2'd1, 28'h00000A0, 28'h00000FF, 6'd3, lat, hit, multi, ridx, vec, to);
        for (int k = 0; k < 3; k++) begin
            ev = model_vec(keys[k]);
            send(2'd0, keys[k], '0, '0, lat, hit, multi, ridx, vec, to);
            checks++; if (vec !== ev || hit !== (|ev) || ridx !== lowest(ev) || multi !== ($countones(ev) > 1))
                begin errors++; $display("FAIL mask_search key=%h got=%h/%b/%0d/%b exp=%h/%b/%0d/%b", keys[k], vec, hit, ridx, multi, ev, |ev, lowest(ev), $countones(ev) > 1); end
        end
    endtask

    task automatic test_erase();
        int lat; logic hit, multi; logic [IW-1:0] ridx; logic [DEPTH-1:0] vec; bit to;
        send(2'd2, '0, '0, 6'd3, lat, hit, multi, ridx, vec, to);
        checks++; if (to || ridx !== 6'd3 || hit !== 1'b0) begin errors++; $display("FAIL erase_ack got=%0d/%b exp=3/0", ridx, hit); end
        send(2'd0, 28'h00000AB, '0, '0, lat, hit, multi, ridx, vec, to);
        checks++; if (ridx !== 6'd9 || multi !== 1'b0 || hit !== 1'b1 || vec !== model_vec(28'h00000AB))
            begin errors++; $display("FAIL erase_search got=%0d/%b/%b exp=9/0/1", ridx, multi, hit); end
    endtask

    task automatic test_illegal();
        int lat; logic hit, multi; logic [IW-1:0] ridx; logic [DEPTH-1:0] vec; bit to;
        send(2'd3, 28'h1234567, '0, 6'd5, lat, hit, multi, ridx, vec, to);
        checks++; if (to || hit !== 1'b0 || ridx !== '0) begin errors++; $display("FAIL illegal_ack got=%b/%0d exp=0/0", hit, ridx); end
        send(2'd0, 28'h1234567, '0, '0, lat, hit, multi, ridx, vec, to);
        checks++; if (hit !== 1'b1 || ridx !== 6'd5) begin errors++; $display("FAIL illegal_kept got=%b/%0d exp=1/5", hit, ridx); end
    endtask

    task automatic test_hold();
        int n = 0; logic h0, m0; logic [IW-1:0] i0; logic [DEPTH-1:0] v0;
        int lat; logic hit, multi; logic [IW-1:0] ridx; logic [DEPTH-1:0] vec; bit to;
        req_valid_i = 1'b1; req_op_i = 2'd0; req_key_i = 28'h1234567;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        while (!rsp_valid_o && n < 50) begin @(posedge clk_i); #1; n++; end
        checks++; if (n >= 50) begin errors++; $display("FAIL hold_rsp_timeout got=%0d exp<50", n); end
        h0 = rsp_hit_o; m0 = rsp_multi_o; i0 = rsp_idx_o; v0 = rsp_vec_o;
        for (int c = 0; c < 5; c++) begin
            req_valid_i = 1'b1; req_op_i = 2'd1; req_idx_i = 6'd5; req_key_i = QW'($urandom);
            @(posedge clk_i); #1;
            checks++; if (!rsp_valid_o || req_ready_o || {rsp_hit_o, rsp_multi_o, rsp_idx_o, rsp_vec_o} !== {h0, m0, i0, v0})
                begin errors++; $display("FAIL hold_stable cyc=%0d valid=%b ready=%b got=%b/%0d/%h exp=%b/%0d/%h", c, rsp_valid_o, req_ready_o, rsp_hit_o, rsp_idx_o, rsp_vec_o, h0, i0, v0); end
        end
        req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("FAIL hold_release valid=%b ready=%b exp=0/1", rsp_valid_o, req_ready_o); end
        $display("txn hold search hit=%b idx=%0d", h0, i0);
        send(2'd0, 28'h1234567, '0, '0, lat, hit, multi, ridx, vec, to);
        checks++; if (hit !== 1'b1 || ridx !== 6'd5 || vec !== model_vec(28'h1234567)) begin errors++; $display("FAIL hold_ignored got=%b/%0d exp=1/5", hit, ridx); end
    endtask

    task automatic test_random();
        int lat; logic hit, multi; logic [IW-1:0] ridx; logic [DEPTH-1:0] vec; bit to;
        logic [QW-1:0] k, mk; logic [IW-1:0] ix; logic [DEPTH-1:0] ev;
        for (int t = 0; t < 30; t++) begin
            int sel = $urandom_range(0, 9);
            ix = IW'($urandom_range(0, 15));
            if (sel < 3) begin
                k = QW'($urandom); mk = QW'($urandom) & QW'($urandom) & QW'($urandom);
                send(2'd1, k, mk, ix, lat, hit, multi, ridx, vec, to);
                checks++; if (to || ridx !== ix || hit !== 1'b0 || vec !== '0) begin errors++; $display("FAIL rand_write got=%0d/%b/%h exp=%0d/0/0", ridx, hit, vec, ix); end
            end else if (sel == 3) begin
                send(2'd2, '0, '0, ix, lat, hit, multi, ridx, vec, to);
                checks++; if (to || ridx !== ix || hit !== 1'b0) begin errors++; $display("FAIL rand_erase got=%0d/%b exp=%0d/0", ridx, hit, ix); end
            end else begin
                k = m_key[ix] ^ (m_mask[ix] & QW'($urandom));
                if (sel == 9) k = QW'($urandom);
                ev = model_vec(k);
                send(2'd0, k, '0, '0, lat, hit, multi, ridx, vec, to);
                checks++; if (to || lat != 2 || vec !== ev || hit !== (|ev) || ridx !== lowest(ev) || multi !== ($countones(ev) > 1))
                    begin errors++; $display("FAIL rand_search key=%h lat=%0d got=%h/%b/%0d/%b exp=%h/%b/%0d/%b", k, lat, vec, hit, ridx, multi, ev, |ev, lowest(ev), $countones(ev) > 1); end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic hit, multi; logic [IW-1:0] ridx; logic [DEPTH-1:0] vec; bit to;
        while (!req_ready_o) begin @(posedge clk_i); #1; end
        req_valid_i = 1'b1; req_op_i = 2'd1; req_key_i = 28'h7654321; req_mask_i = '0; req_idx_i = 6'd7;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        repeat (40) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        checks++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_state ready=%b valid=%b exp=1/0", req_ready_o, rsp_valid_o); end
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        $display("txn reset during write idx=7 row=40");
        send(2'd0, 28'h7654321, '0, '0, lat, hit, multi, ridx, vec, to);
        checks++; if (to || hit !== 1'b0 || vec !== '0) begin errors++; $display("FAIL midreset_search got=%b/%h exp=0/0", hit, vec); end
        send(2'd1, 28'h7654321, '0, 6'd7, lat, hit, multi, ridx, vec, to);
        send(2'd0, 28'h7654321, '0, '0, lat, hit, multi, ridx, vec, to);
        checks++; if (hit !== 1'b1 || ridx !== 6'd7 || vec !== model_vec(28'h7654321)) begin errors++; $display("FAIL midreset_rewrite got=%b/%0d exp=1/7", hit, ridx); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin m_key[i] = '0; m_mask[i] = '0; m_valid[i] = 1'b0; end
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        test_reset();
        test_search_empty();
        test_write_basic();
        test_mask();
        test_erase();
        test_illegal();
        test_hold();
        test_random();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
